// File: rtl/ibuf_multi_if.sv
// Fetch-side and decode-side handshake bundle for the ibuf_multi instruction queue.
// slave is the queue itself; master is the fetch unit plus decode consumer.
interface ibuf_multi_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int PC_WIDTH    = 48
);
    logic                      enq_valid;
    logic                      enq_ready;
    logic [FETCH_WIDTH*32-1:0] enq_inst;
    logic [PC_WIDTH-1:0]       enq_pc;
    logic [FETCH_WIDTH-1:0]    enq_mask;
    logic                      deq_valid;
    logic                      deq_ready;
    logic [31:0]               deq_inst;
    logic [PC_WIDTH-1:0]       deq_pc;

    modport master (
        output enq_valid, enq_inst, enq_pc, enq_mask, deq_ready,
        input  enq_ready, deq_valid, deq_inst, deq_pc
    );

    modport slave (
        input  enq_valid, enq_inst, enq_pc, enq_mask, deq_ready,
        output enq_ready, deq_valid, deq_inst, deq_pc
    );
endinterface

// File: rtl/ibuf_multi.sv
// Multi-slot instruction buffer: compacts masked fetch blocks into a circular queue, pops one per cycle.
// Optional same-cycle empty-queue bypass is enabled by defining IBUF_BYPASS_EN.
module ibuf_multi #(
    parameter int FETCH_WIDTH   = 2,
    parameter int DEPTH         = 16,
    parameter int PC_WIDTH      = 48,
    parameter int REFILL_THRESH = DEPTH - FETCH_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    ibuf_multi_if.slave                bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       fetch_req
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]            inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem   [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count_next;
    logic [CNT_W-1:0]       write_count;
    logic [PTR_W-1:0]       slot_offset [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] write_mask;
    logic [DEPTH-1:0]       we;
    logic [31:0]            w_inst [DEPTH];
    logic [PC_WIDTH-1:0]    w_pc   [DEPTH];
    logic                   enq_ready_int;
    logic                   enq_fire;
    logic                   stor_deq;
`ifdef IBUF_BYPASS_EN
    logic                   bypass_found;
`endif

    assign enq_ready_int = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign bus.enq_ready = enq_ready_int;
    assign empty         = (count == '0);
    assign full          = (count == CNT_W'(DEPTH));

    // Head selection, optional bypass, and compaction of set mask bits into consecutive offsets
    always_comb begin
        enq_fire      = bus.enq_valid && enq_ready_int && !flush;
        write_mask    = enq_fire ? bus.enq_mask : '0;
        stor_deq      = bus.deq_ready && (count != '0) && !flush;
        bus.deq_valid = (count != '0);
        bus.deq_inst  = inst_mem[rd_ptr];
        bus.deq_pc    = pc_mem[rd_ptr];
`ifdef IBUF_BYPASS_EN
        bypass_found = 1'b0;
        if ((count == '0) && enq_fire && (bus.enq_mask != '0)) begin
            bus.deq_valid = 1'b1;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (!bypass_found && bus.enq_mask[i]) begin
                    bypass_found = 1'b1;
                    bus.deq_inst = bus.enq_inst[32*i +: 32];
                    bus.deq_pc   = bus.enq_pc + PC_WIDTH'(4*i);
                    if (bus.deq_ready) write_mask[i] = 1'b0;
                end
            end
        end
`endif
        write_count = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_offset[i] = PTR_W'(write_count);
            write_count    = write_count + CNT_W'(write_mask[i]);
        end
        count_next = count + write_count - CNT_W'(stor_deq);
        if (flush) count_next = '0;
    end

    // Scatter surviving slots onto their storage entries
    always_comb begin
        we = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_inst[e] = '0;
            w_pc[e]   = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (write_mask[i]) begin
                we[wr_ptr + slot_offset[i]]     = 1'b1;
                w_inst[wr_ptr + slot_offset[i]] = bus.enq_inst[32*i +: 32];
                w_pc[wr_ptr + slot_offset[i]]   = bus.enq_pc + PC_WIDTH'(4*i);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (we[e]) begin
                inst_mem[e] <= w_inst[e];
                pc_mem[e]   <= w_pc[e];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            fetch_req <= 1'b0;
        end else begin
            fetch_req <= !flush && (count_next <= CNT_W'(REFILL_THRESH));
            count     <= count_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(write_count);
                if (stor_deq) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ibuf_multi.sv
// Directed bench for ibuf_multi at FETCH_WIDTH=2, DEPTH=8, PC_WIDTH=48 (refill threshold 6).
// Expectations follow the bypass variant when IBUF_BYPASS_EN is defined.
module tb_ibuf_multi;
`ifdef IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       flush;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       fetch_req;
    int         passed;
    int         total;

    ibuf_multi_if #(.FETCH_WIDTH(2), .PC_WIDTH(48)) bus ();

    ibuf_multi #(.FETCH_WIDTH(2), .DEPTH(8), .PC_WIDTH(48)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .fetch_req (fetch_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ev;
        logic [1:0]  mask;
        logic [63:0] inst;
        logic [47:0] pc;
        logic        dr;
        logic        fl;
        logic        edv;
        logic        chk;
        logic [31:0] einst;
        logic [47:0] epc;
        logic [3:0]  ecnt;
        logic        erdy;
        logic        efr;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic ev, logic [1:0] mask, logic [63:0] inst, logic [47:0] pc,
                                logic dr, logic fl, logic edv, logic chk, logic [31:0] einst,
                                logic [47:0] epc, logic [3:0] ecnt, logic erdy, logic efr);
        vec_t v;
        v.ev = ev; v.mask = mask; v.inst = inst; v.pc = pc; v.dr = dr; v.fl = fl;
        v.edv = edv; v.chk = chk; v.einst = einst; v.epc = epc;
        v.ecnt = ecnt; v.erdy = erdy; v.efr = efr;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic ev, input logic [1:0] mask, input logic [63:0] inst,
                         input logic [47:0] pc, input logic dr, input logic fl);
        bus.enq_valid = ev;
        bus.enq_mask  = mask;
        bus.enq_inst  = inst;
        bus.enq_pc    = pc;
        bus.deq_ready = dr;
        flush         = fl;
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        drive(v.ev, v.mask, v.inst, v.pc, v.dr, v.fl);
        #1;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check_val($sformatf("v%0d.deq_valid", idx), 64'(bus.deq_valid), 64'(v.edv));
        if (v.chk) begin
            check_val($sformatf("v%0d.deq_inst", idx), 64'(bus.deq_inst), 64'(v.einst));
            check_val($sformatf("v%0d.deq_pc", idx), 64'(bus.deq_pc), 64'(v.epc));
        end
        check_val($sformatf("v%0d.count", idx), 64'(count), 64'(v.ecnt));
        check_val($sformatf("v%0d.empty", idx), 64'(empty), 64'(v.ecnt == 4'd0));
        check_val($sformatf("v%0d.full", idx), 64'(full), 64'(v.ecnt == 4'd8));
        check_val($sformatf("v%0d.enq_ready", idx), 64'(bus.enq_ready), 64'(v.erdy));
        check_val($sformatf("v%0d.fetch_req", idx), 64'(fetch_req), 64'(v.efr));
    endtask

    initial begin
        logic [63:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f;
        passed  = 0;
        total   = 0;
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b0, 1'b0);

        blk_a = {32'h0000_00A1, 32'h0000_00A0};
        blk_b = {32'h0000_00B1, 32'h0000_00B0};
        blk_c = {32'h0000_00C1, 32'h0000_00C0};
        blk_d = {32'h0000_00D1, 32'h0000_00D0};
        blk_e = {32'h0000_00E1, 32'h0000_00E0};
        blk_f = {32'h0000_00F1, 32'h0000_00F0};

        vecs[0]  = mk(0, 2'b00, 64'h0, 48'h0, 0, 0, 0, 0, 32'h0, 48'h0, 4'd0, 1, 1);
        vecs[1]  = mk(1, 2'b11, {32'h0010_0093, 32'h0000_0013}, 48'h8000_0000, 0, 0,
                      BYP, BYP, 32'h0000_0013, 48'h8000_0000, 4'd0, 1, 1);
        vecs[2]  = mk(0, 2'b00, 64'h0, 48'h0, 1, 0, 1, 1, 32'h0000_0013, 48'h8000_0000, 4'd2, 1, 1);
        vecs[3]  = mk(0, 2'b00, 64'h0, 48'h0, 1, 0, 1, 1, 32'h0010_0093, 48'h8000_0004, 4'd1, 1, 1);
        vecs[4]  = mk(0, 2'b00, 64'h0, 48'h0, 0, 0, 0, 0, 32'h0, 48'h0, 4'd0, 1, 1);
        vecs[5]  = mk(1, 2'b11, blk_a, 48'h100, 0, 0, BYP, BYP, 32'hA0, 48'h100, 4'd0, 1, 1);
        vecs[6]  = mk(1, 2'b11, blk_b, 48'h200, 0, 0, 1, 1, 32'hA0, 48'h100, 4'd2, 1, 1);
        vecs[7]  = mk(1, 2'b11, blk_c, 48'h300, 0, 0, 1, 1, 32'hA0, 48'h100, 4'd4, 1, 1);
        vecs[8]  = mk(1, 2'b11, blk_d, 48'h400, 0, 0, 1, 1, 32'hA0, 48'h100, 4'd6, 1, 1);
        vecs[9]  = mk(1, 2'b11, blk_e, 48'h500, 0, 0, 1, 1, 32'hA0, 48'h100, 4'd8, 0, 0);
        vecs[10] = mk(1, 2'b11, blk_e, 48'h500, 1, 0, 1, 1, 32'hA0, 48'h100, 4'd8, 0, 0);
        vecs[11] = mk(1, 2'b11, blk_e, 48'h500, 0, 0, 1, 1, 32'hA1, 48'h104, 4'd7, 0, 0);
        vecs[12] = mk(1, 2'b11, blk_e, 48'h500, 1, 0, 1, 1, 32'hA1, 48'h104, 4'd7, 0, 0);
        vecs[13] = mk(1, 2'b11, blk_e, 48'h500, 0, 0, 1, 1, 32'hB0, 48'h200, 4'd6, 1, 1);
        vecs[14] = mk(0, 2'b00, 64'h0, 48'h0, 0, 0, 1, 1, 32'hB0, 48'h200, 4'd8, 0, 0);
        vecs[15] = mk(0, 2'b00, 64'h0, 48'h0, 1, 0, 1, 1, 32'hB0, 48'h200, 4'd8, 0, 0);
        vecs[16] = mk(0, 2'b00, 64'h0, 48'h0, 1, 0, 1, 1, 32'hB1, 48'h204, 4'd7, 0, 0);
        vecs[17] = mk(0, 2'b00, 64'h0, 48'h0, 1, 0, 1, 1, 32'hC0, 48'h300, 4'd6, 1, 1);
        vecs[18] = mk(1, 2'b11, blk_f, 48'h600, 1, 1, 1, 1, 32'hC1, 48'h304, 4'd5, 1, 1);
        vecs[19] = mk(0, 2'b00, 64'h0, 48'h0, 0, 0, 0, 0, 32'h0, 48'h0, 4'd0, 1, 0);
        vecs[20] = mk(0, 2'b00, 64'h0, 48'h0, 0, 0, 0, 0, 32'h0, 48'h0, 4'd0, 1, 1);

        #12;
        check_val("rst.count", 64'(count), 64'd0);
        check_val("rst.empty", 64'(empty), 64'd1);
        check_val("rst.full", 64'(full), 64'd0);
        check_val("rst.deq_valid", 64'(bus.deq_valid), 64'd0);
        check_val("rst.enq_ready", 64'(bus.enq_ready), 64'd1);
        check_val("rst.fetch_req", 64'(fetch_req), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // Offset the pointers by two so the single-slot rounds wrap past entry 7
        @(negedge clock); drive(1'b1, 2'b11, blk_a, 48'h3000, 1'b0, 1'b0);
        @(negedge clock); drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b1, 1'b0);
        @(negedge clock); drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b1, 1'b0);
        for (int r = 0; r < 7; r++) begin
            @(negedge clock);
            drive(1'b1, 2'b10, {32'hC000_0000 + 32'(r), 32'hDEAD_BEEF}, 48'h1000, 1'b0, 1'b0);
            #1;
            check_val($sformatf("wrap%0d.enq_count", r), 64'(count), 64'd0);
            check_val($sformatf("wrap%0d.enq_deq_valid", r), 64'(bus.deq_valid), 64'(BYP));
            @(negedge clock);
            drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b1, 1'b0);
            #1;
            check_val($sformatf("wrap%0d.deq_valid", r), 64'(bus.deq_valid), 64'd1);
            check_val($sformatf("wrap%0d.deq_inst", r), 64'(bus.deq_inst), 64'(32'hC000_0000 + 32'(r)));
            check_val($sformatf("wrap%0d.deq_pc", r), 64'(bus.deq_pc), 64'h1004);
            check_val($sformatf("wrap%0d.count", r), 64'(count), 64'd1);
        end

        @(negedge clock);
        drive(1'b1, 2'b11, blk_e, 48'h2000, 1'b1, 1'b0);
        #1;
        check_val("byp.deq_valid", 64'(bus.deq_valid), 64'(BYP));
`ifdef IBUF_BYPASS_EN
        check_val("byp.deq_inst", 64'(bus.deq_inst), 64'hE0);
        check_val("byp.deq_pc", 64'(bus.deq_pc), 64'h2000);
`endif
        @(negedge clock);
        drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b0, 1'b0);
        #1;
        check_val("byp.next_deq_valid", 64'(bus.deq_valid), 64'd1);
`ifdef IBUF_BYPASS_EN
        check_val("byp.next_count", 64'(count), 64'd1);
        check_val("byp.next_inst", 64'(bus.deq_inst), 64'hE1);
        check_val("byp.next_pc", 64'(bus.deq_pc), 64'h2004);
`else
        check_val("byp.next_count", 64'(count), 64'd2);
        check_val("byp.next_inst", 64'(bus.deq_inst), 64'hE0);
        check_val("byp.next_pc", 64'(bus.deq_pc), 64'h2000);
`endif

        @(negedge clock); drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b0, 1'b1);
        @(negedge clock); drive(1'b1, 2'b11, blk_a, 48'h10, 1'b0, 1'b0);
        @(negedge clock); drive(1'b1, 2'b11, blk_b, 48'h20, 1'b0, 1'b0);
        @(negedge clock); drive(1'b1, 2'b01, blk_c, 48'h30, 1'b0, 1'b0);
        @(negedge clock); drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b1, 1'b0);
        #1;
        check_val("mid.count_before", 64'(count), 64'd5);
        #1;
        reset_n = 1'b0;
        drive(1'b0, 2'b00, 64'h0, 48'h0, 1'b0, 1'b0);
        #1;
        check_val("mid.count", 64'(count), 64'd0);
        check_val("mid.deq_valid", 64'(bus.deq_valid), 64'd0);
        check_val("mid.enq_ready", 64'(bus.enq_ready), 64'd1);
        check_val("mid.fetch_req", 64'(fetch_req), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check_val("mid.fetch_after", 64'(fetch_req), 64'd1);
        check_val("mid.count_after", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
